// File: rtl/pc_target_table.sv
// Programmable branch-target table with a hit flag for unprogrammed slots.
// The program loader fills entries at boot. Fetch then issues one lookup per branch and
// receives either an absolute target or a PC-relative target.
// After every reset a sweep clears all valid bits, one entry per cycle.
module pc_target_table #(
  parameter int unsigned D     = 10,
  parameter int unsigned A     = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  output logic         init_busy,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         rd_req,
  input  logic [A-1:0] rd_addr,
  input  logic [D-1:0] rd_pc,
  input  logic         rd_rel,
  output logic         rd_valid,
  output logic [D-1:0] target,
  output logic         hit
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A:0]      DepthExt = (A + 1)'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [D-1:0]      mem_q [DEPTH];
  logic              rd_valid_q, rd_valid_d;
  logic [D-1:0]      target_q, target_d;
  logic              hit_q, hit_d;

  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;
  logic              wr_fire, rd_fire, bypass, entry_hit;
  logic [D-1:0]      entry;

  // Address decode, range checks and the same-address write-through bypass.
  always_comb begin
    wr_idx      = wr_addr[IdxW-1:0];
    rd_idx      = rd_addr[IdxW-1:0];
    wr_in_range = {1'b0, wr_addr} < DepthExt;
    rd_in_range = {1'b0, rd_addr} < DepthExt;
    wr_fire     = (state_q == StRun) && wr_en && wr_in_range;
    rd_fire     = (state_q == StRun) && rd_req;
    bypass      = wr_fire && (wr_addr == rd_addr);
    entry       = bypass ? wr_data : mem_q[rd_idx];
    // rd_in_range also masks rd_idx aliasing onto a real entry.
    entry_hit   = rd_in_range && (bypass || valid_q[rd_idx]);
  end

  // Next state: clear sweep in StInit, valid-bit set on writes in StRun.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      StInit: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (wr_fire) valid_d[wr_idx] = 1'b1;
      end
    endcase
  end

  // Lookup result; target and hit hold between requests.
  always_comb begin
    rd_valid_d = rd_fire;
    target_d   = target_q;
    hit_d      = hit_q;
    if (rd_fire) begin
      hit_d = entry_hit;
      if (!entry_hit)  target_d = '0;
      else if (rd_rel) target_d = rd_pc + entry; // signed offset, wraps mod 2^D
      else             target_d = entry;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      target_q   <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      target_q   <= target_d;
      hit_q      <= hit_d;
    end
  end

  // Valid bits need no reset value; the sweep after reset clears them.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= valid_d;
  end

  // Entry storage, plain registers without reset.
  always_ff @(posedge clk) begin
    if (reset && wr_fire) mem_q[wr_idx] <= wr_data;
  end

  assign init_busy = !reset || (state_q == StInit);
  assign rd_valid  = rd_valid_q;
  assign target    = target_q;
  assign hit       = hit_q;

endmodule
